mc_ctrl_fsm: RTL and testbench

//  Multi-cycle control sequencer for the RV32I core. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/mc_ctrl_if.sv | 35 +++
 rtl/mc_ctrl_fsm.sv | 191 +++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the datapath/memory port.
// Latency: none, wires only.
// Backpressure: memory stalls arrive as mem_ready low; no other flow control.
interface mc_ctrl_if;
  logic [31:0] instr;
  logic        mem_ready;
  logic        br_cond;
  logic        mem_req;
  logic        mem_we;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_sel;
  logic [2:0]  imm_sel;
  logic        alu_src_a;
  logic        alu_src_b;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic [2:0]  state;
  logic        bus_err;
  logic        trap;

  // Sequencer side: consumes datapath status, drives strobes.
  modport master (
    input  instr, mem_ready, br_cond,
    output mem_req, mem_we, ir_write, pc_write, pc_sel, imm_sel,
           alu_src_a, alu_src_b, reg_write, wb_sel, state, bus_err, trap
  );

  // Datapath/memory side.
  modport slave (
    output instr, mem_ready, br_cond,
    input  mem_req, mem_we, ir_write, pc_write, pc_sel, imm_sel,
           alu_src_a, alu_src_b, reg_write, wb_sel, state, bus_err, trap
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// RV32I multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with memory watchdog.
// Latency: ALU/U/J 4 cycles, load 5, store 4, branch 3 (zero-wait memory).
// Backpressure: holds FETCH/MEM while mem_ready is low; ERR after WAIT_MAX+1 stalled cycles.
// Optional: define ILLEGAL_TRAP_EN to trap on illegal opcodes (otherwise they run as NOPs).
module mc_ctrl_fsm #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  mc_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_U    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_NONE = 3'd7;

  state_t           state_q;
  logic [6:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic             legal;
  logic             timeout;

  // Only the opcode field steers the sequencer; the rest of the word belongs to the datapath.
  logic unused_instr_hi;
  assign unused_instr_hi = ^bus.instr[31:7];

  assign timeout = (cnt == CNT_W'(WAIT_MAX)) && !bus.mem_ready;

  // Opcode legality check on the live IR word, used only in DECODE.
  always_comb begin
    case (bus.instr[6:0])
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_OPIMM, OP_OP: legal = 1'b1;
      default:                            legal = 1'b0;
    endcase
  end

  // Sequencer state, latched opcode and memory watchdog; cnt is zeroed on every entry to FETCH/MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= 7'd0;
      cnt     <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (bus.mem_ready)  state_q <= S_DECODE;
          else if (timeout)   state_q <= S_ERR;
          else                cnt     <= cnt + 1'b1;
        end
        S_DECODE: begin
          op_q <= bus.instr[6:0];
          if (legal) begin
            state_q <= S_EXEC;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            state_q <= S_TRAP;
`else
            state_q <= S_FETCH;
            cnt     <= '0;
`endif
          end
        end
        S_EXEC: begin
          if (op_q == OP_LOAD || op_q == OP_STORE) begin
            state_q <= S_MEM;
            cnt     <= '0;
          end else if (op_q == OP_BRANCH) begin
            state_q <= S_FETCH;
            cnt     <= '0;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            if (op_q == OP_STORE) begin
              state_q <= S_FETCH;
              cnt     <= '0;
            end else begin
              state_q <= S_WB;
            end
          end else if (timeout) begin
            state_q <= S_ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WB: begin
          state_q <= S_FETCH;
          cnt     <= '0;
        end
        S_ERR, S_TRAP: state_q <= state_q;
        default: begin
          state_q <= S_FETCH;
          cnt     <= '0;
        end
      endcase
    end
  end

  // Moore decode from state/op_q; FETCH strobes follow mem_ready, branch pc_write follows br_cond; all forced low in reset.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.ir_write  = 1'b0;
    bus.pc_write  = 1'b0;
    bus.pc_sel    = 2'd0;
    bus.imm_sel   = 3'd0;
    bus.alu_src_a = 1'b0;
    bus.alu_src_b = 1'b0;
    bus.reg_write = 1'b0;
    bus.wb_sel    = 2'd0;
    bus.state     = 3'd0;
    bus.bus_err   = 1'b0;
    bus.trap      = 1'b0;
    if (!rst) begin
      bus.state   = state_q;
      bus.imm_sel = IMM_NONE;
      // Operand setup is held steady through EXEC, MEM and WB so the ALU result stays valid.
      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
        case (op_q)
          OP_OPIMM, OP_LOAD, OP_JALR: begin bus.imm_sel = IMM_I; bus.alu_src_b = 1'b1; end
          OP_STORE:  begin bus.imm_sel = IMM_S; bus.alu_src_b = 1'b1; end
          OP_BRANCH: bus.imm_sel = IMM_B;
          OP_LUI:    bus.imm_sel = IMM_U;
          OP_AUIPC:  begin bus.imm_sel = IMM_U; bus.alu_src_a = 1'b1; bus.alu_src_b = 1'b1; end
          OP_JAL:    begin bus.imm_sel = IMM_J; bus.alu_src_a = 1'b1; bus.alu_src_b = 1'b1; end
          default:   bus.imm_sel = IMM_NONE;
        endcase
      end
      case (state_q)
        S_FETCH: begin
          bus.mem_req  = 1'b1;
          bus.ir_write = bus.mem_ready;
          bus.pc_write = bus.mem_ready;
        end
        S_EXEC: begin
          if (op_q == OP_BRANCH) begin
            bus.pc_write = bus.br_cond;
            bus.pc_sel   = 2'd1;
          end
        end
        S_MEM: begin
          bus.mem_req = 1'b1;
          bus.mem_we  = (op_q == OP_STORE);
        end
        S_WB: begin
          bus.reg_write = 1'b1;
          case (op_q)
            OP_LOAD: bus.wb_sel = 2'd1;
            OP_LUI:  bus.wb_sel = 2'd3;
            OP_JAL:  begin bus.wb_sel = 2'd2; bus.pc_write = 1'b1; bus.pc_sel = 2'd1; end
            OP_JALR: begin bus.wb_sel = 2'd2; bus.pc_write = 1'b1; bus.pc_sel = 2'd2; end
            default: bus.wb_sel = 2'd0;
          endcase
        end
        S_ERR: bus.bus_err = 1'b1;
`ifdef ILLEGAL_TRAP_EN
        S_TRAP: bus.trap = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: instruction-level plans expand into per-cycle expected output vectors.
// Latency: one expected vector per clock, compared mid-cycle by an independent monitor.
// Backpressure: memory wait states and timeouts are injected through mem_ready.
module tb_mc_ctrl_fsm;
  localparam int WAIT_MAX = 15;

  localparam int P_RST = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3, P_MEM = 4, P_WB = 5, P_ERR = 6, P_TRAP = 7;

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011, LOAD = 7'b0000011, STORE = 7'b0100011;
  localparam logic [6:0] OPIMM = 7'b0010011, OP = 7'b0110011;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic [2:0] imm_sel;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       bus_err;
    logic       trap;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_ctrl_if bus();
  mc_ctrl_fsm #(.WAIT_MAX(WAIT_MAX), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  vec_t exp_q[$];
  vec_t msk_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic [6:0] ops [9] = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP};

  function automatic bit is_legal(input logic [6:0] op);
    for (int i = 0; i < 9; i++) if (ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference: what the datapath must see in one cycle of a given instruction phase.
  function automatic void model(input int ph, input logic [6:0] op, input bit rdy, input bit br,
                                output vec_t e, output vec_t m);
    bit setup, pcs_care;
    e = '0; m = '1; setup = 1'b0; pcs_care = 1'b0;
    case (ph)
      P_FETCH:  begin e.state = 3'd0; e.mem_req = 1'b1; e.ir_write = rdy; e.pc_write = rdy; end
      P_DECODE: e.state = 3'd1;
      P_EXEC: begin
        e.state = 3'd2; setup = 1'b1;
        if (op == BRANCH) begin e.pc_write = br; e.pc_sel = 2'd1; pcs_care = 1'b1; end
      end
      P_MEM: begin e.state = 3'd3; setup = 1'b1; e.mem_req = 1'b1; e.mem_we = (op == STORE); end
      P_WB: begin
        e.state = 3'd4; setup = 1'b1; e.reg_write = 1'b1;
        case (op)
          LOAD:    e.wb_sel = 2'd1;
          LUI:     e.wb_sel = 2'd3;
          JAL:     begin e.wb_sel = 2'd2; e.pc_write = 1'b1; e.pc_sel = 2'd1; end
          JALR:    begin e.wb_sel = 2'd2; e.pc_write = 1'b1; e.pc_sel = 2'd2; end
          default: e.wb_sel = 2'd0;
        endcase
      end
      P_ERR:  begin e.state = 3'd5; e.bus_err = 1'b1; end
      P_TRAP: begin e.state = 3'd6; e.trap = 1'b1; end
      default: ;
    endcase
    if (setup) begin
      case (op)
        OP:     begin e.alu_src_a = 1'b0; e.alu_src_b = 1'b0; m.imm_sel = '0; end
        OPIMM, LOAD, JALR: begin e.imm_sel = 3'd0; e.alu_src_b = 1'b1; end
        STORE:  begin e.imm_sel = 3'd1; e.alu_src_b = 1'b1; end
        AUIPC:  begin e.imm_sel = 3'd3; e.alu_src_a = 1'b1; e.alu_src_b = 1'b1; end
        LUI:    begin e.imm_sel = 3'd3; m.alu_src_a = 1'b0; m.alu_src_b = 1'b0; end
        JAL:    begin e.imm_sel = 3'd4; m.alu_src_a = 1'b0; m.alu_src_b = 1'b0; end
        BRANCH: begin e.imm_sel = 3'd2; m.alu_src_a = 1'b0; m.alu_src_b = 1'b0; end
        default: ;
      endcase
    end
    if (ph != P_RST) begin
      m.mem_we = e.mem_req;
      m.pc_sel = {2{e.pc_write | pcs_care}};
      m.wb_sel = {2{e.reg_write}};
      if (!setup) begin m.imm_sel = '0; m.alu_src_a = 1'b0; m.alu_src_b = 1'b0; end
    end
  endfunction

  // Drive one cycle of inputs and queue the response that cycle must produce.
  task automatic step(input int ph, input logic [6:0] op, input bit rdy, input bit br, input logic [31:0] iv);
    vec_t e, m;
    rst           = (ph == P_RST);
    bus.mem_ready = rdy;
    bus.br_cond   = br;
    bus.instr     = iv;
    model(ph, op, rdy, br, e, m);
    exp_q.push_back(e);
    msk_q.push_back(m);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    repeat (2) step(P_RST, 7'd0, rb(), rb(), $urandom);
  endtask

  // Expand one instruction into its cycle plan. outcome: 0 done, 1 bus error, 2 trap, 3 aborted in MEM.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input bit br,
                           input bit abort_mem, output int outcome);
    logic [6:0] op;
    int n;
    op = ins[6:0];
    outcome = 0;
    n = (fw > WAIT_MAX) ? WAIT_MAX + 1 : fw;
    for (int i = 0; i < n; i++) step(P_FETCH, op, 1'b0, rb(), $urandom);
    if (fw > WAIT_MAX) begin outcome = 1; return; end
    step(P_FETCH, op, 1'b1, rb(), $urandom);
    step(P_DECODE, op, rb(), rb(), ins);
    if (!is_legal(op)) begin
`ifdef ILLEGAL_TRAP_EN
      outcome = 2;
`endif
      return;
    end
    step(P_EXEC, op, rb(), br, $urandom);
    if (op == BRANCH) return;
    if (op == LOAD || op == STORE) begin
      n = (mw > WAIT_MAX) ? WAIT_MAX + 1 : mw;
      for (int i = 0; i < n; i++) step(P_MEM, op, 1'b0, rb(), $urandom);
      if (abort_mem) begin outcome = 3; return; end
      if (mw > WAIT_MAX) begin outcome = 1; return; end
      step(P_MEM, op, 1'b1, rb(), $urandom);
      if (op == STORE) return;
    end
    step(P_WB, op, rb(), rb(), $urandom);
  endtask

  task automatic settle(input int outcome);
    if (outcome == 1) repeat (3) step(P_ERR, 7'd0, rb(), rb(), $urandom);
    if (outcome == 2) repeat (3) step(P_TRAP, 7'd0, rb(), rb(), $urandom);
    if (outcome != 0) do_reset();
  endtask

  // Monitor: the DUT presents an output vector every cycle; compare it against the oldest expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      vec_t act, e, m;
      act.state = bus.state;       act.mem_req = bus.mem_req;     act.mem_we = bus.mem_we;
      act.ir_write = bus.ir_write; act.pc_write = bus.pc_write;   act.pc_sel = bus.pc_sel;
      act.imm_sel = bus.imm_sel;   act.alu_src_a = bus.alu_src_a; act.alu_src_b = bus.alu_src_b;
      act.reg_write = bus.reg_write; act.wb_sel = bus.wb_sel;     act.bus_err = bus.bus_err;
      act.trap = bus.trap;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL underrun t=%0t act=%h required=<queued vector>", $time, act);
      end else begin
        e = exp_q.pop_front();
        m = msk_q.pop_front();
        if (((act ^ e) & m) !== '0) begin
          errors++;
          $display("FAIL out_vec t=%0t act=%h required=%h care=%h", $time, act, e, m);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int oc, fw, mw, sel;
    logic [31:0] r, ins;
    logic [6:0] op;
    rst = 1'b1; bus.mem_ready = 1'b0; bus.br_cond = 1'b0; bus.instr = '0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    do_reset();

    run_instr(32'h00500093, 0, 0, 1'b0, 1'b0, oc); settle(oc);   // addi
    run_instr(32'h0000A103, 0, 3, 1'b0, 1'b0, oc); settle(oc);   // lw, 3 wait states
    run_instr(32'h00208463, 0, 0, 1'b1, 1'b0, oc); settle(oc);   // beq taken
    run_instr(32'h00208463, 0, 0, 1'b0, 1'b0, oc); settle(oc);   // beq not taken
    run_instr(32'h008000EF, 0, 0, 1'b0, 1'b0, oc); settle(oc);   // jal
    run_instr(32'h000080E7, 1, 0, 1'b0, 1'b0, oc); settle(oc);   // jalr
    run_instr(32'h0020A023, 2, 1, 1'b0, 1'b0, oc); settle(oc);   // sw
    run_instr(32'h00500093, 16, 0, 1'b0, 1'b0, oc); settle(oc);  // fetch timeout -> ERR
    run_instr(32'h00500093, 15, 0, 1'b0, 1'b0, oc); settle(oc);  // ready on last allowed cycle
    run_instr(32'h0000A103, 0, 15, 1'b0, 1'b0, oc); settle(oc);  // MEM ready on last allowed cycle
    run_instr(32'h0000A103, 0, 16, 1'b0, 1'b0, oc); settle(oc);  // MEM timeout -> ERR
    run_instr(32'hFFFFFFFF, 0, 0, 1'b0, 1'b0, oc); settle(oc);   // illegal opcode
    run_instr(32'h0020A023, 0, 2, 1'b0, 1'b1, oc); settle(oc);   // reset while store waits in MEM
    run_instr(32'h12345037, 0, 0, 1'b0, 1'b0, oc); settle(oc);   // lui
    run_instr(32'h00001297, 0, 0, 1'b0, 1'b0, oc); settle(oc);   // auipc

    for (int k = 0; k < 80; k++) begin
      r = $urandom;
      sel = $urandom_range(0, 11);
      if (sel < 9)       op = ops[sel];
      else if (sel == 9) op = {r[6:2], r[1], 1'b0};
      else               op = OPIMM;
      ins = {r[31:7], op};
      fw = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 16) : $urandom_range(0, 3);
      mw = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 16) : $urandom_range(0, 3);
      run_instr(ins, fw, mw, rb(), ($urandom_range(0, 19) == 0), oc);
      settle(oc);
    end

    mon_en = 1'b0;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover act=%0d required=0 queued vectors", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
